neuron_mac_act: RTL and testbench

- Single binary-input neuron: computes bias plus the sum of the 10-bit signed weights whose input bit is 1.
- Result is saturated to 10 bits, then passed through a step activation to give a 1-bit output.
- One instance per output neuron of the fully connected layer; four instances share the same 16-bit input vector.
- Sequential: processes one input bit per clock under a start/done handshake.

---
 rtl/neuron_mac_act.sv | 107 ++++++++++
 tb/tb_neuron_mac_act.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_act.sv
// Binary-input neuron: bias plus the weights gated by in_bits, one input per clock,
// saturated to W bits and passed through a step activation.
module neuron_mac_act #(
   parameter int N_IN  = 16,
   parameter int W     = 10,
   parameter int ACC_W = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [N_IN-1:0]   in_bits,
   input  logic [N_IN*W-1:0] weights,
   input  logic [W-1:0]      bias,
   output logic              busy,
   output logic              done,
   output logic [W-1:0]      mac_out,
   output logic              act_out
);

   localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);
   localparam int MAX_I = 2 ** (W - 1) - 1;
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(MAX_I);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-MAX_I - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACC,
      S_OUT
   } state_t;

   state_t                  state;
   state_t                  state_n;
   logic [N_IN-1:0]         bits_q;
   logic signed [W-1:0]     w_q [N_IN];
   logic signed [ACC_W-1:0] acc;
   logic [IDX_W-1:0]        idx;

   logic signed [W-1:0]     w_sel;
   logic signed [ACC_W-1:0] w_ext;
   logic signed [ACC_W-1:0] bias_ext;
   logic [W-1:0]            sat;

   // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  if (start) state_n = S_ACC;
         S_ACC:   if (idx == LAST_IDX) state_n = S_OUT;
         S_OUT:   state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_n;
   end

   assign busy     = (state != S_IDLE);
   assign w_sel    = w_q[idx];
   assign w_ext    = ACC_W'(w_sel);
   assign bias_ext = ACC_W'($signed(bias));

   always_comb begin
      sat = acc[W-1:0];
      if (acc > SAT_MAX)      sat = SAT_MAX[W-1:0];
      else if (acc < SAT_MIN) sat = SAT_MIN[W-1:0];
   end

   // NOTE: the latched weight array is reset explicitly so an aborted run leaves no stale operands.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bits_q  <= '0;
         acc     <= '0;
         idx     <= '0;
         done    <= 1'b0;
         mac_out <= '0;
         act_out <= 1'b0;
         for (int i = 0; i < N_IN; i++) w_q[i] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  bits_q <= in_bits;
                  for (int i = 0; i < N_IN; i++) w_q[i] <= weights[i*W +: W];
                  acc    <= bias_ext;
                  idx    <= '0;
               end
            end
            S_ACC: begin
               if (bits_q[idx]) acc <= acc + w_ext;
               idx <= idx + 1'b1;
            end
            S_OUT: begin
               mac_out <= sat;
               act_out <= ~sat[W-1];
               done    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_mac_act.sv
// Directed self-checking bench for neuron_mac_act with hand-computed expectations.
module tb_neuron_mac_act;

   localparam int N_IN  = 16;
   localparam int W     = 10;
   localparam int ACC_W = 15;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic [N_IN-1:0]   in_bits = '0;
   logic [N_IN*W-1:0] weights = '0;
   logic [W-1:0]      bias = '0;
   logic              busy;
   logic              done;
   logic [W-1:0]      mac_out;
   logic              act_out;

   int errors = 0;
   int checks = 0;

   neuron_mac_act #(.N_IN(N_IN), .W(W), .ACC_W(ACC_W)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .in_bits (in_bits),
      .weights (weights),
      .bias    (bias),
      .busy    (busy),
      .done    (done),
      .mac_out (mac_out),
      .act_out (act_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [N_IN*W-1:0] fill(input logic [W-1:0] w);
      logic [N_IN*W-1:0] f;
      for (int i = 0; i < N_IN; i++) f[i*W +: W] = w;
      return f;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts edges until done is seen, bounded so a dead DUT cannot hang the run.
   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic run_eval(input string tag, input logic [N_IN-1:0] b_in,
                           input logic [N_IN*W-1:0] w_in, input logic [W-1:0] bs,
                           input logic [W-1:0] exp_mac, input logic exp_act);
      int n;
      in_bits = b_in;
      weights = w_in;
      bias    = bs;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      check({tag, "_busy"}, 32'(busy), 32'd1);
      wait_done(n);
      check({tag, "_latency"}, 32'(n), 32'd17);
      check({tag, "_mac"}, 32'(mac_out), 32'(exp_mac));
      check({tag, "_act"}, 32'(act_out), 32'(exp_act));
      check({tag, "_busy_end"}, 32'(busy), 32'd0);
      tick();
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_hold"}, 32'(mac_out), 32'(exp_mac));
   endtask

   initial begin
      logic [N_IN*W-1:0] w_mix;
      int n_done;
      int n;
      logic [W-1:0] mac_seen;

      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_mac", 32'(mac_out), 32'd0);
      check("rst_act", 32'(act_out), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      tick();

      run_eval("ones",   16'hFFFF, fill(10'h001), 10'h000, 10'h010, 1'b1);
      run_eval("neg",    16'hFFFF, fill(10'h3FF), 10'h000, 10'h3F0, 1'b0);
      run_eval("satpos", 16'hFFFF, fill(10'h1FF), 10'h1FF, 10'h1FF, 1'b1);
      run_eval("satneg", 16'hFFFF, fill(10'h200), 10'h200, 10'h200, 1'b0);
      run_eval("gate_m1", 16'h0000, fill(10'h1FF), 10'h3FF, 10'h3FF, 1'b0);
      run_eval("gate_z",  16'h0000, fill(10'h1FF), 10'h000, 10'h000, 1'b1);
      w_mix = fill(10'h001);
      w_mix[0*W +: W]  = 10'h005;
      w_mix[15*W +: W] = 10'h007;
      run_eval("mix", 16'h8001, w_mix, 10'h000, 10'h00C, 1'b1);

      // Second start mid-run with changed inputs must be ignored.
      in_bits = 16'hFFFF;
      weights = fill(10'h001);
      bias    = 10'h000;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      repeat (4) tick();
      start   = 1'b1;
      in_bits = 16'h0000;
      bias    = 10'h3FF;
      tick();
      start   = 1'b0;
      n_done   = 0;
      mac_seen = '0;
      repeat (30) begin
         tick();
         if (done) begin
            n_done++;
            mac_seen = mac_out;
         end
      end
      check("ign_done_cnt", 32'(n_done), 32'd1);
      check("ign_mac", 32'(mac_seen), 32'h010);

      // start held high: the next evaluation begins on the edge right after done.
      in_bits = 16'h0003;
      weights = fill(10'h002);
      bias    = 10'h001;
      start   = 1'b1;
      tick();
      wait_done(n);
      check("held_lat1", 32'(n), 32'd17);
      check("held_mac1", 32'(mac_out), 32'h005);
      tick();
      check("held_busy", 32'(busy), 32'd1);
      start = 1'b0;
      wait_done(n);
      check("held_lat2", 32'(n + 1), 32'd18);
      tick();

      // Reset mid-run aborts without a done pulse.
      in_bits = 16'hFFFF;
      weights = fill(10'h001);
      bias    = 10'h000;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      repeat (7) tick();
      reset = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_mac", 32'(mac_out), 32'd0);
      check("abort_act", 32'(act_out), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      repeat (3) tick();
      reset  = 1'b1;
      n_done = 0;
      repeat (20) begin
         tick();
         if (done) n_done++;
      end
      check("abort_no_done", 32'(n_done), 32'd0);
      run_eval("after_rst", 16'h8001, w_mix, 10'h000, 10'h00C, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
